// File: rtl/alu_serial_rx.sv
// Serial frame receiver: assembles {A, B, opcode} from 10-bit parity words into one ALU request.
// Optional parity checking is enabled by defining ALU_SERIAL_RX_PARITY_CHECK_EN.
module alu_serial_rx (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable_n,
   input  logic       din,
   output logic [7:0] a,
   output logic [7:0] b,
   output logic [7:0] op,
   output logic [2:0] err,
   output logic       req_valid,
   input  logic       req_ready,
   output logic       overrun
);

   typedef enum logic [1:0] {WAIT_A, WAIT_B, WAIT_CMD} state_e;

   state_e      state_q;
   logic [3:0]  bitcnt_q, bitcnt_d;
   logic [8:0]  shift_q, shift_d;
   logic [7:0]  a_hold_q, b_hold_q;
   logic        frame_q, count_q, par_q;
   logic [7:0]  a_q, b_q, op_q;
   logic [2:0]  err_q;
   logic        valid_q, overrun_q;

   logic [9:0]  word;
   logic        word_done, abort, pbad, is_cmd, xfer, drop;
   logic [7:0]  data;

   always_comb begin
      word      = {shift_q, din};
      is_cmd    = word[9];
      data      = word[8:1];
      word_done = !enable_n && (bitcnt_q == 4'd9);
      abort     = enable_n && (bitcnt_q != 4'd0);
      xfer      = valid_q && req_ready;
      drop      = valid_q && !req_ready;
`ifdef ALU_SERIAL_RX_PARITY_CHECK_EN
      pbad      = ^word;
`else
      pbad      = 1'b0;
`endif
      shift_d   = shift_q;
      bitcnt_d  = '0;
      if (!enable_n) begin
         shift_d  = {shift_q[7:0], din};
         bitcnt_d = word_done ? 4'd0 : 4'(bitcnt_q + 4'd1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= WAIT_A;
         bitcnt_q  <= '0;
         shift_q   <= '0;
         a_hold_q  <= '0;
         b_hold_q  <= '0;
         frame_q   <= 1'b0;
         count_q   <= 1'b0;
         par_q     <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         err_q     <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         bitcnt_q  <= bitcnt_d;
         shift_q   <= shift_d;
         overrun_q <= 1'b0;
         if (xfer)  valid_q <= 1'b0;
         if (abort) frame_q <= 1'b1;
         if (word_done) begin
            if (!is_cmd) begin
               if (pbad) par_q <= 1'b1;
               case (state_q)
                  WAIT_A: begin
                     a_hold_q <= data;
                     state_q  <= WAIT_B;
                  end
                  WAIT_B: begin
                     b_hold_q <= data;
                     state_q  <= WAIT_CMD;
                  end
                  default: count_q <= 1'b1;
               endcase
            end else begin
               // A held bundle not being taken this edge means the new frame is lost.
               if (drop) begin
                  overrun_q <= 1'b1;
               end else begin
                  a_q     <= (state_q == WAIT_A)   ? 8'h00 : a_hold_q;
                  b_q     <= (state_q == WAIT_CMD) ? b_hold_q : 8'h00;
                  op_q    <= data;
                  err_q   <= {frame_q, count_q | (state_q != WAIT_CMD), par_q | pbad};
                  valid_q <= 1'b1;
               end
               frame_q <= 1'b0;
               count_q <= 1'b0;
               par_q   <= 1'b0;
               state_q <= WAIT_A;
            end
         end
      end
   end

   assign a         = a_q;
   assign b         = b_q;
   assign op        = op_q;
   assign err       = err_q;
   assign req_valid = valid_q;
   assign overrun   = overrun_q;

endmodule
